// File: rtl/stream_mux_arbiter.sv
// Round-robin packet arbiter sharing one AXI-Stream master among NUM_REQ capture submodules.
// A grant is held from the metadata beat through tlast; only the granted requester sees ready.
module stream_mux_arbiter #(
    parameter int NUM_REQ    = 5,
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_in_progress,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          pkt_count,
    output logic [CNT_WIDTH-1:0]          abort_count
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                               state;
    logic [IW-1:0]                        rr_ptr;
    logic [IW-1:0]                        g_idx;
    logic                                 first_busy;
    logic [NUM_REQ-1:0]                   elig;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_beats;
    logic [DATA_WIDTH-1:0]                mux_data;
    logic                                 mux_valid;
    logic                                 mux_last;
    logic                                 mux_inprog;
    logic                                 pick_found;
    logic [IW-1:0]                        pick_idx;
    logic [IW-1:0]                        rr_next;
    logic                                 pkt_done;
    int                                   idx;

    assign elig      = req_valid | req_in_progress;
    assign req_beats = req_data;

    // Grant is zero in IDLE, so the AND-OR mux drives all stream outputs low there.
    always_comb begin
        mux_data   = '0;
        mux_valid  = 1'b0;
        mux_last   = 1'b0;
        mux_inprog = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mux_data   = mux_data | req_beats[i];
                mux_valid  = mux_valid | req_valid[i];
                mux_last   = mux_last | req_last[i];
                mux_inprog = mux_inprog | req_in_progress[i];
            end
        end
    end

    assign m_axis_tdata  = mux_data;
    assign m_axis_tvalid = mux_valid;
    assign m_axis_tlast  = mux_valid & mux_last;
    // Ready depends only on the grant register, never on req_valid.
    assign req_ready     = grant & {NUM_REQ{m_axis_tready}};
    assign busy          = (state == BUSY);
    assign pkt_done      = mux_valid & mux_last & m_axis_tready;
    assign rr_next       = (g_idx == LAST_IDX) ? '0 : g_idx + 1'b1;

    // First eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_found && elig[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            grant       <= '0;
            g_idx       <= '0;
            rr_ptr      <= '0;
            first_busy  <= 1'b0;
            pkt_count   <= '0;
            abort_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state      <= BUSY;
                        grant      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        g_idx      <= pick_idx;
                        first_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    first_busy <= 1'b0;
                    if (pkt_done) begin
                        state     <= IDLE;
                        grant     <= '0;
                        rr_ptr    <= rr_next;
                        pkt_count <= pkt_count + 1'b1;
                    end else if (!first_busy && !mux_valid && !mux_inprog) begin
                        // Withdrawn before its metadata beat: rr_ptr stays so it keeps priority.
                        state       <= IDLE;
                        grant       <= '0;
                        abort_count <= abort_count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_mux_arbiter.sv
// Directed bench for stream_mux_arbiter with a small per-requester packet source model.
module tb_stream_mux_arbiter;
    localparam int N  = 5;
    localparam int DW = 16;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [N-1:0]      req_valid, req_in_progress, req_last, req_ready, grant;
    logic [N*DW-1:0]   req_data;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid, m_axis_tlast, m_axis_tready, busy;
    logic [CW-1:0]     pkt_count, abort_count;

    int total = 0;
    int bad   = 0;
    int rem[N];
    int beat[N];
    int base[N];
    bit hold[N];
    bit refill[N];
    int refill_len;

    stream_mux_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_in_progress(req_in_progress),
        .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .grant(grant), .busy(busy), .pkt_count(pkt_count), .abort_count(abort_count)
    );

    always #5 clk = ~clk;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = (rem[i] > 0) && !hold[i];
            req_in_progress[i]    = (rem[i] > 0) && (beat[i] > 0) && !hold[i];
            req_last[i]           = (rem[i] == 1);
            req_data[i*DW +: DW]  = DW'(base[i] + beat[i]);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; beat[i] = 0; base[i] = i << 8; hold[i] = 0; refill[i] = 0;
        end
        refill_len = 1;
    endtask

    // One clock: record handshakes before the edge, advance sources after it.
    task automatic step();
        logic [N-1:0] hs;
        hs = req_ready & req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                beat[i]++;
                rem[i]--;
                if (rem[i] == 0 && refill[i]) begin
                    rem[i] = refill_len; beat[i] = 0;
                end
            end
        end
        drive();
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        m_axis_tready = 1'b1;
        clear_model();
        drive();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        clear_model();
        rem[0] = 1;
        m_axis_tready = 1'b1;
        drive();
        repeat (2) @(negedge clk);
        total++;
        if ({grant, req_ready, m_axis_tvalid, m_axis_tlast, busy, m_axis_tdata, pkt_count, abort_count} !== '0) begin
            bad++;
            $display("FAIL reset_state grant=%b ready=%b tvalid=%b tlast=%b busy=%b tdata=%h pkt=%0d abort=%0d want all zero",
                     grant, req_ready, m_axis_tvalid, m_axis_tlast, busy, m_axis_tdata, pkt_count, abort_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        base[2] = 'hA; rem[2] = 3;
        drive(); #1;
        total++;
        if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            bad++; $display("FAIL single_idle busy=%b tvalid=%b want 0 0", busy, m_axis_tvalid);
        end
        step();
        total++;
        if (grant !== 5'b00100 || m_axis_tdata !== 16'hA || m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b0) begin
            bad++; $display("FAIL single_beat0 grant=%b tdata=%h tvalid=%b tlast=%b want 00100 000a 1 0",
                            grant, m_axis_tdata, m_axis_tvalid, m_axis_tlast);
        end
        step();
        total++;
        if (m_axis_tdata !== 16'hB || m_axis_tlast !== 1'b0) begin
            bad++; $display("FAIL single_beat1 tdata=%h tlast=%b want 000b 0", m_axis_tdata, m_axis_tlast);
        end
        step();
        total++;
        if (m_axis_tdata !== 16'hC || m_axis_tlast !== 1'b1) begin
            bad++; $display("FAIL single_beat2 tdata=%h tlast=%b want 000c 1", m_axis_tdata, m_axis_tlast);
        end
        step();
        total++;
        if (busy !== 1'b0 || grant !== '0 || pkt_count !== 4'd1) begin
            bad++; $display("FAIL single_done busy=%b grant=%b pkt=%0d want 0 00000 1", busy, grant, pkt_count);
        end
        // rr_ptr is now 3: requester 4 must beat requester 0.
        rem[0] = 1; rem[4] = 1;
        drive();
        step();
        total++;
        if (grant !== 5'b10000) begin
            bad++; $display("FAIL single_rrptr grant=%b want 10000", grant);
        end
        step(); step();
        total++;
        if (grant !== 5'b00001) begin
            bad++; $display("FAIL single_wrap_grant grant=%b want 00001", grant);
        end
        step();
        total++;
        if (pkt_count !== 4'd3 || busy !== 1'b0) begin
            bad++; $display("FAIL single_count pkt=%0d busy=%b want 3 0", pkt_count, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        do_reset();
        refill_len = 2;
        for (int i = 0; i < N; i++) begin
            refill[i] = 1; rem[i] = 2;
        end
        drive();
        for (int p = 0; p < 6; p++) begin
            exp_g = '0;
            exp_g[p % N] = 1'b1;
            step();
            total++;
            if (grant !== exp_g || m_axis_tvalid !== 1'b1) begin
                bad++; $display("FAIL rr_grant pkt=%0d grant=%b tvalid=%b want %b 1", p, grant, m_axis_tvalid, exp_g);
            end
            step();
            total++;
            if (m_axis_tlast !== 1'b1) begin
                bad++; $display("FAIL rr_last pkt=%0d tlast=%b want 1", p, m_axis_tlast);
            end
            step();
            total++;
            if (busy !== 1'b0 || grant !== '0) begin
                bad++; $display("FAIL rr_idle_gap pkt=%0d busy=%b grant=%b want 0 00000", p, busy, grant);
            end
        end
        total++;
        if (pkt_count !== 4'd6) begin
            bad++; $display("FAIL rr_count pkt=%0d want 6", pkt_count);
        end
    endtask

    task automatic test_backpressure();
        logic [DW+1:0] snap;
        do_reset();
        base[1] = 'h20; rem[1] = 4;
        drive();
        step();
        total++;
        if (m_axis_tdata !== 16'h20 || req_ready !== 5'b00010) begin
            bad++; $display("FAIL bp_first tdata=%h ready=%b want 0020 00010", m_axis_tdata, req_ready);
        end
        step();
        m_axis_tready = 1'b0;
        #1;
        snap = {m_axis_tdata, m_axis_tvalid, m_axis_tlast};
        total++;
        if (snap !== {16'h21, 1'b1, 1'b0} || req_ready !== '0) begin
            bad++; $display("FAIL bp_stall_enter beat=%h ready=%b want 21/1/0 00000", snap, req_ready);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if ({m_axis_tdata, m_axis_tvalid, m_axis_tlast} !== {16'h21, 1'b1, 1'b0} || req_ready !== '0 || grant !== 5'b00010) begin
                bad++; $display("FAIL bp_stall_hold cyc=%0d tdata=%h tvalid=%b tlast=%b ready=%b grant=%b want 0021 1 0 00000 00010",
                                c, m_axis_tdata, m_axis_tvalid, m_axis_tlast, req_ready, grant);
            end
        end
        m_axis_tready = 1'b1;
        #1;
        total++;
        if (req_ready !== 5'b00010) begin
            bad++; $display("FAIL bp_ready_mirror ready=%b want 00010", req_ready);
        end
        step();
        total++;
        if (m_axis_tdata !== 16'h22) begin
            bad++; $display("FAIL bp_resume tdata=%h want 0022", m_axis_tdata);
        end
        step();
        total++;
        if (m_axis_tdata !== 16'h23 || m_axis_tlast !== 1'b1) begin
            bad++; $display("FAIL bp_last tdata=%h tlast=%b want 0023 1", m_axis_tdata, m_axis_tlast);
        end
        step();
        total++;
        if (busy !== 1'b0 || pkt_count !== 4'd1) begin
            bad++; $display("FAIL bp_done busy=%b pkt=%0d want 0 1", busy, pkt_count);
        end
    endtask

    task automatic test_abandon();
        do_reset();
        rem[2] = 1;
        drive();
        step(); step();
        rem[3] = 2;
        drive();
        step();
        total++;
        if (grant !== 5'b01000) begin
            bad++; $display("FAIL abandon_grant grant=%b want 01000", grant);
        end
        hold[3] = 1;
        drive(); #1;
        step();
        total++;
        if (busy !== 1'b1 || abort_count !== 4'd0) begin
            bad++; $display("FAIL abandon_first_cycle busy=%b abort=%0d want 1 0", busy, abort_count);
        end
        step();
        total++;
        if (busy !== 1'b0 || abort_count !== 4'd1 || pkt_count !== 4'd1 || grant !== '0) begin
            bad++; $display("FAIL abandon_idle busy=%b abort=%0d pkt=%0d grant=%b want 0 1 1 00000",
                            busy, abort_count, pkt_count, grant);
        end
        hold[3] = 0; rem[0] = 1; rem[4] = 1;
        drive();
        step();
        total++;
        if (grant !== 5'b01000) begin
            bad++; $display("FAIL abandon_keeps_priority grant=%b want 01000", grant);
        end
        rem[0] = 0; rem[4] = 0;
        drive();
        step(); step();
        total++;
        if (busy !== 1'b0 || pkt_count !== 4'd2) begin
            bad++; $display("FAIL abandon_retry_done busy=%b pkt=%0d want 0 2", busy, pkt_count);
        end
    endtask

    task automatic test_async_reset();
        base[1] = 'h40; rem[1] = 4;
        drive();
        step(); step(); step();
        #2 resetn = 1'b0;
        #1;
        total++;
        if ({req_ready, m_axis_tvalid, m_axis_tlast, grant, busy, pkt_count, abort_count} !== '0) begin
            bad++; $display("FAIL async_reset ready=%b tvalid=%b tlast=%b grant=%b busy=%b pkt=%0d abort=%0d want all zero",
                            req_ready, m_axis_tvalid, m_axis_tlast, grant, busy, pkt_count, abort_count);
        end
        clear_model();
        rem[1] = 4; rem[4] = 1;
        drive();
        @(negedge clk);
        resetn = 1'b1;
        step();
        total++;
        if (grant !== 5'b00010) begin
            bad++; $display("FAIL async_reset_regrant grant=%b want 00010", grant);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        refill[0] = 1; refill_len = 1; rem[0] = 1;
        drive();
        for (int p = 0; p < 16; p++) begin
            step(); step();
        end
        total++;
        if (pkt_count !== 4'd0) begin
            bad++; $display("FAIL wrap_16 pkt=%0d want 0", pkt_count);
        end
        step(); step();
        total++;
        if (pkt_count !== 4'd1 || busy !== 1'b0) begin
            bad++; $display("FAIL wrap_17 pkt=%0d busy=%b want 1 0", pkt_count, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_abandon();
        test_async_reset();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
